// File: rtl/rs_syndrome_accumulator_pkg.sv
// Shared GF(2^W) definitions for the RS decode front end.
package rs_syndrome_accumulator_pkg;

    localparam int          N            = 7;
    localparam int          SYMBOL_WIDTH = 3;
    // x^3 + x + 1; bit W is the implicit leading term
    localparam logic [SYMBOL_WIDTH:0] PRIM_POLY = 4'b1011;

    localparam int          CW_W  = N * SYMBOL_WIDTH;
    localparam int          CNT_W = $clog2(N);

endpackage

// File: rtl/rs_syndrome_accumulator_if.sv
// Symbol-in / codeword-out handshake bundle of the syndrome accumulator.
interface rs_syndrome_accumulator_if;
    import rs_syndrome_accumulator_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [SYMBOL_WIDTH-1:0] in_symbol;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW_W-1:0]         out_codeword;
    logic [SYMBOL_WIDTH-1:0] out_s1;
    logic [SYMBOL_WIDTH-1:0] out_s2;
    logic                    frame_err;

    modport slave (
        input  in_valid, in_symbol, in_last, out_ready,
        output in_ready, out_valid, out_codeword, out_s1, out_s2, frame_err
    );

    modport master (
        output in_valid, in_symbol, in_last, out_ready,
        input  in_ready, out_valid, out_codeword, out_s1, out_s2, frame_err
    );

endinterface

// File: rtl/rs_syndrome_accumulator_gf_mul_alpha.sv
// Combinational multiply by alpha (=x) in GF(2^W), polynomial basis.
module gf_mul_alpha #(
    parameter int           W         = 3,
    parameter logic [W:0]   PRIM_POLY = 4'b1011
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = {a_i[W-2:0], 1'b0} ^ (a_i[W-1] ? PRIM_POLY[W-1:0] : '0);

endmodule

// File: rtl/rs_syndrome_accumulator.sv
// Assembles received RS symbols into a codeword while accumulating S1/S2
// by Horner's rule; double-buffered output with valid/ready handshake.
module rs_syndrome_accumulator
    import rs_syndrome_accumulator_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    rs_syndrome_accumulator_if.slave    bus
);

    localparam int W = SYMBOL_WIDTH;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW_W-1:0]  cw_acc_q, cw_next;
    logic [W-1:0]     s1_acc_q, s1_next;
    logic [W-1:0]     s2_acc_q, s2_next;
    logic [CW_W-1:0]  out_cw_q, out_cw_d;
    logic [W-1:0]     out_s1_q, out_s1_d;
    logic [W-1:0]     out_s2_q, out_s2_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    logic [W-1:0]     s1_mul, s2_mul_a, s2_mul;
    logic             at_last, first, in_ready, accept;

    gf_mul_alpha #(.W(W), .PRIM_POLY(PRIM_POLY)) u_s1_mul  (.a_i(s1_acc_q), .y_o(s1_mul));
    gf_mul_alpha #(.W(W), .PRIM_POLY(PRIM_POLY)) u_s2_mul0 (.a_i(s2_acc_q), .y_o(s2_mul_a));
    gf_mul_alpha #(.W(W), .PRIM_POLY(PRIM_POLY)) u_s2_mul1 (.a_i(s2_mul_a), .y_o(s2_mul));

    assign at_last  = (cnt_q == CNT_W'(N - 1));
    assign first    = (cnt_q == '0);
    // Stall only when a completion would overwrite an output not yet taken
    assign in_ready = !(at_last && out_valid_q && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // First symbol of a frame loads directly so no stale state leaks in
    always_comb begin
        cw_next = CW_W'(bus.in_symbol);
        s1_next = bus.in_symbol;
        s2_next = bus.in_symbol;
        if (!first) begin
            cw_next = {cw_acc_q[CW_W-W-1:0], bus.in_symbol};
            s1_next = s1_mul ^ bus.in_symbol;
            s2_next = s2_mul ^ bus.in_symbol;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_cw_d    = out_cw_q;
        out_s1_d    = out_s1_q;
        out_s2_d    = out_s2_q;
        out_valid_d = out_valid_q;
        frame_err_d = frame_err_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (at_last) begin
                cnt_d       = '0;
                out_cw_d    = cw_next;
                out_s1_d    = s1_next;
                out_s2_d    = s2_next;
                out_valid_d = 1'b1;
                if (!bus.in_last) frame_err_d = 1'b1;
            end else if (bus.in_last) begin
                cnt_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            out_cw_q    <= '0;
            out_s1_q    <= '0;
            out_s2_q    <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_cw_q    <= out_cw_d;
            out_s1_q    <= out_s1_d;
            out_s2_q    <= out_s2_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Accumulators need no reset: cnt==0 always reloads them
    always_ff @(posedge clk) begin
        if (accept) begin
            cw_acc_q <= cw_next;
            s1_acc_q <= s1_next;
            s2_acc_q <= s2_next;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_codeword = out_cw_q;
    assign bus.out_s1       = out_s1_q;
    assign bus.out_s2       = out_s2_q;
    assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_rs_syndrome_accumulator.sv
// Bench for rs_syndrome_accumulator: directed steps plus random frames
// checked each cycle against a frame-level reference model.
module tb_rs_syndrome_accumulator;
    import rs_syndrome_accumulator_pkg::*;

    localparam int W = SYMBOL_WIDTH;
    typedef logic [W-1:0] sym_q_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rs_syndrome_accumulator_if bus();

    rs_syndrome_accumulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: symbols of the frame in progress, held output
    logic [W-1:0]    cur[$];
    logic            m_valid;
    logic            m_err;
    logic [CW_W-1:0] m_cw;
    logic [W-1:0]    m_s1;
    logic [W-1:0]    m_s2;
    bit              rand_ready;
    bit              gaps;

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [15:0] p;
        logic [15:0] poly;
        p    = '0;
        poly = 16'(PRIM_POLY);
        for (int i = 0; i < W; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 2 * W - 2; k >= W; k--)
            if (p[k]) p = p ^ (poly << (k - W));
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] alpha_pow(input int e);
        logic [W-1:0] p;
        p = W'(1);
        for (int i = 0; i < e; i++) p = gf_mul(p, W'(2));
        return p;
    endfunction

    function automatic sym_q_t rand_frame(input int len);
        sym_q_t q;
        for (int i = 0; i < len; i++) q.push_back(W'($urandom_range(0, (1 << W) - 1)));
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_frame();
        logic [W-1:0] r;
        m_cw = '0;
        m_s1 = '0;
        m_s2 = '0;
        for (int i = 0; i < N; i++) begin
            r    = cur[N-1-i];
            m_cw = m_cw | (CW_W'(r) << (i * W));
            m_s1 = m_s1 ^ gf_mul(r, alpha_pow(i));
            m_s2 = m_s2 ^ gf_mul(r, alpha_pow(2 * i));
        end
    endtask

    task automatic clk_cycle(output bit accepted);
        bit exp_ready;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp_ready = !(cur.size() == N - 1 && m_valid && !bus.out_ready);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("frame_err", 32'(bus.frame_err), 32'(m_err));
        if (m_valid) begin
            chk("out_codeword", 32'(bus.out_codeword), 32'(m_cw));
            chk("out_s1", 32'(bus.out_s1), 32'(m_s1));
            chk("out_s2", 32'(bus.out_s2), 32'(m_s2));
        end
        accepted = bus.in_valid && exp_ready;
        if (m_valid && bus.out_ready) m_valid = 1'b0;
        if (accepted) begin
            if (bus.in_last && cur.size() < N - 1) begin
                cur.delete();
                m_err = 1'b1;
            end else begin
                cur.push_back(bus.in_symbol);
                if (cur.size() == N) begin
                    expect_frame();
                    m_valid = 1'b1;
                    if (!bus.in_last) m_err = 1'b1;
                    cur.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < n; i++) clk_cycle(acc);
    endtask

    task automatic send_sym(input logic [W-1:0] sym, input bit last);
        bit acc;
        acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_symbol = sym;
        bus.in_last   = last;
        for (int t = 0; t < 100 && !acc; t++) clk_cycle(acc);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (gaps) idle($urandom_range(0, 1));
    endtask

    task automatic send_frame(input sym_q_t s, input int last_idx);
        for (int k = 0; k < s.size(); k++) send_sym(s[k], k == last_idx);
    endtask

    task automatic do_reset(input int n);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        cur.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cw    = '0;
        m_s1    = '0;
        m_s2    = '0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_codeword", 32'(bus.out_codeword), 32'd0);
        chk("rst_s1", 32'(bus.out_s1), 32'd0);
        chk("rst_s2", 32'(bus.out_s2), 32'd0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sym_q_t fr;
        sym_q_t fr2;
        bit acc;
        bus.in_valid  = 1'b0;
        bus.in_symbol = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rand_ready    = 1'b0;
        gaps          = 1'b0;

        do_reset(3);

        // All-zero frame
        fr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        send_frame(fr, 6);
        chk("zero_valid", 32'(bus.out_valid), 32'd1);
        chk("zero_cw", 32'(bus.out_codeword), 32'h0);
        chk("zero_s1", 32'(bus.out_s1), 32'd0);
        chk("zero_s2", 32'(bus.out_s2), 32'd0);
        chk("zero_err", 32'(bus.frame_err), 32'd0);
        idle(1);

        // Single-term frames
        fr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        send_frame(fr, 6);
        chk("r1_cw", 32'(bus.out_codeword), 32'h000008);
        chk("r1_s1", 32'(bus.out_s1), 32'd2);
        chk("r1_s2", 32'(bus.out_s2), 32'd4);
        idle(1);
        fr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
        send_frame(fr, 6);
        chk("r2_s1", 32'(bus.out_s1), 32'd4);
        chk("r2_s2", 32'(bus.out_s2), 32'd6);
        idle(1);

        // Back-to-back frames, no gaps
        send_frame(rand_frame(N), N - 1);
        send_frame(rand_frame(N), N - 1);
        idle(2);

        // Backpressure across frame 1 and frame 2
        bus.out_ready = 1'b0;
        send_frame(rand_frame(N), N - 1);
        fr2 = rand_frame(N);
        for (int k = 0; k < N - 1; k++) send_sym(fr2[k], 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_symbol = fr2[N-1];
        bus.in_last   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clk_cycle(acc);
            chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        clk_cycle(acc);
        chk("bp_accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("bp_valid_kept", 32'(bus.out_valid), 32'd1);
        chk("bp_frame2_s1", 32'(bus.out_s1), 32'(m_s1));
        idle(2);

        // Early in_last, then a good frame
        send_frame(rand_frame(3), 2);
        chk("early_err", 32'(bus.frame_err), 32'd1);
        idle(2);
        send_frame(rand_frame(N), N - 1);
        chk("after_early_valid", 32'(bus.out_valid), 32'd1);
        idle(2);
        chk("err_sticky", 32'(bus.frame_err), 32'd1);

        // Reset mid-frame
        send_frame(rand_frame(4), -1);
        do_reset(1);
        send_frame(rand_frame(N), N - 1);
        idle(2);

        // Missing in_last: frame still emitted, error flagged
        send_frame(rand_frame(N), -1);
        chk("missing_last_err", 32'(bus.frame_err), 32'd1);
        idle(2);

        // Random traffic with random backpressure and gaps
        do_reset(1);
        rand_ready = 1'b1;
        gaps       = 1'b1;
        for (int f = 0; f < 12; f++) begin
            int len;
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, N - 1)) : N;
            fr  = rand_frame(len);
            send_frame(fr, ($urandom_range(0, 7) == 0) ? -1 : len - 1);
        end
        rand_ready    = 1'b0;
        gaps          = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
